memory_sp_m: RTL and testbench
==============================

MEMORY_SP_M -- requirements
Module: memory_sp_m

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter AWIDTH, default 5, address width; depth = 2**AWIDTH words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles from accepted read to data driven (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data  inout  DWIDTH  bidirectional data bus; sampled on write, driven on read.
REQ-007 SHALL have port addr  input  AWIDTH  word address.
REQ-008 SHALL have port read  input  1  read request, level-sampled at clk.
REQ-009 SHALL have port write  input  1  write request, level-sampled at clk.
REQ-010 SHALL have port ready  output  1  block accepts a command this cycle.
REQ-011 SHALL have port rvalid  output  1  data bus driven with read data this cycle.
REQ-012 SHALL have port cmd_err  output  1  one-cycle pulse on illegal command.
REQ-013 SHALL have port perr  output  1  parity error flag qualified by rvalid.

Function
REQ-014 SHALL implement FSM states INIT, IDLE, RD_WAIT, RD_DRIVE.
REQ-015 INIT SHALL write zero to address 0..2**AWIDTH-1, one word per cycle via an internal sweep counter, then go to IDLE; ready=0 throughout.
REQ-016 ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, write=1 and read=0 SHALL store data into mem[addr] at that clk edge; FSM stays IDLE; zero-latency back-to-back writes allowed.
REQ-018 In IDLE, read=1 and write=0 SHALL latch addr, go to RD_WAIT if RD_LAT>1 else RD_DRIVE.
REQ-019 RD_WAIT SHALL count RD_LAT-1 cycles, then go to RD_DRIVE.
REQ-020 RD_DRIVE SHALL last exactly one cycle: data driven with mem[latched addr], rvalid=1, then IDLE.
REQ-021 data SHALL be high-impedance in every cycle except RD_DRIVE.
REQ-022 read=1 and write=1 together in IDLE SHALL be ignored (no store, no read) and pulse cmd_err for one cycle.
REQ-023 Commands presented while ready=0 SHALL be ignored without cmd_err.
REQ-024 A write to the address of an in-flight read is impossible (ready=0); read data SHALL reflect contents at read acceptance.
REQ-025 addr SHALL wrap naturally; no out-of-range address exists.

Reset
REQ-026 rst_n low SHALL asynchronously force state INIT, sweep counter 0, ready=0, rvalid=0, cmd_err=0, perr=0, data released to high-impedance.
REQ-027 Reset mid-read SHALL abort the read with no rvalid; reset mid-INIT SHALL restart the sweep at address 0.
REQ-028 Memory contents SHALL be undefined during reset and all-zero once ready first rises.

Configuration
REQ-029 Macro MEMORY_SP_M_PARITY_EN defined SHALL store an extra even-parity bit per word, computed on write and on INIT (parity 0), and check it in RD_DRIVE; perr=1 with rvalid on mismatch.
REQ-030 Without MEMORY_SP_M_PARITY_EN SHALL store no parity bit and tie perr to 0; port list unchanged.

Verification (DWIDTH=8, AWIDTH=5, RD_LAT=2)
REQ-031 Release rst_n -> ready=0 for exactly 32 cycles then 1; read of addr 31 returns 0x00 with rvalid.
REQ-032 Write 0xA5 to addr 3, then read addr 3 -> rvalid=1 and data=0xA5 exactly 2 cycles after read acceptance; data high-Z the cycles before and after.
REQ-033 read=1 and write=1 in IDLE at addr 7 holding 0x3C -> cmd_err pulses one cycle; addr 7 still reads 0x00.
REQ-034 Assert rst_n low during RD_WAIT -> rvalid never asserts; INIT re-sweeps; addr 3 reads 0x00 afterwards.
REQ-035 With MEMORY_SP_M_PARITY_EN, force-flip stored bit 0 of addr 5 after writing 0x01 -> read returns 0x00 with perr=1 and rvalid=1.

Source files
------------

// File: rtl/memory_sp_m.sv
// Single-port word memory with zero-fill INIT sweep; parity option via MEMORY_SP_M_PARITY_EN.
// Latency: writes commit at the accepting edge; read data on the bus RD_LAT cycles after acceptance.
// Backpressure: ready is high only in IDLE; commands presented while ready=0 are dropped silently.
`timescale 1ns/1ps
module memory_sp_m #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DWIDTH-1:0] data,
  input  logic [AWIDTH-1:0] addr,
  input  logic              read,
  input  logic              write,
  output logic              ready,
  output logic              rvalid,
  output logic              cmd_err,
  output logic              perr
);

`ifdef MEMORY_SP_M_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW    = DWIDTH + PW;
  localparam int DEPTH = 2**AWIDTH;
  // Last RD_WAIT count value; unused when RD_LAT == 1.
  localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RD_DRIVE} state_t;

  state_t            state;
  logic [AWIDTH-1:0] sweep_cnt;
  logic [1:0]        wait_cnt;
  logic [MW-1:0]     rd_word;
  logic [MW-1:0]     mem [DEPTH];

  logic              mem_we;
  logic [AWIDTH-1:0] mem_wa;
  logic [MW-1:0]     mem_wd;
  logic [MW-1:0]     wr_word;

`ifdef MEMORY_SP_M_PARITY_EN
  assign wr_word = {^data, data};
`else
  assign wr_word = data;
`endif

  // INIT owns the write port; afterwards only a clean IDLE write uses it.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr;
    mem_wd = wr_word;
    if (state == INIT) begin
      mem_we = 1'b1;
      mem_wa = sweep_cnt;
      mem_wd = '0;
    end else if (state == IDLE && write && !read) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
      wait_cnt  <= '0;
      rd_word   <= '0;
      ready     <= 1'b0;
      rvalid    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      rvalid  <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + AWIDTH'(1);
          if (&sweep_cnt) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (read && write) begin
            cmd_err <= 1'b1;
          end else if (read) begin
            // Capture now: no write can land before the word is driven.
            rd_word <= mem[addr];
            ready   <= 1'b0;
            if (RD_LAT > 1) begin
              state    <= RD_WAIT;
              wait_cnt <= '0;
            end else begin
              state  <= RD_DRIVE;
              rvalid <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state  <= RD_DRIVE;
            rvalid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RD_DRIVE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // rvalid is high exactly in RD_DRIVE, so it doubles as the bus enable.
  assign data = rvalid ? rd_word[DWIDTH-1:0] : {DWIDTH{1'bz}};

`ifdef MEMORY_SP_M_PARITY_EN
  assign perr = rvalid & (^rd_word);
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_memory_sp_m.sv
// Bench for memory_sp_m (DWIDTH=8, AWIDTH=5, RD_LAT=2): vector table plus reset/bus corner sequences.
`timescale 1ns/1ps
module tb_memory_sp_m;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  wire  [DW-1:0] data;
  logic [DW-1:0] tb_dat = '0;
  logic          tb_drv = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic          ready, rvalid, cmd_err, perr;

  assign data = tb_drv ? tb_dat : {DW{1'bz}};

  memory_sp_m #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .read(read),
    .write(write), .ready(ready), .rvalid(rvalid), .cmd_err(cmd_err), .perr(perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          due;
    logic [DW-1:0] dat;
    logic        perr;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] ed;
    logic          eerr;
    logic          erdy;
  } vec_t;
  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] ed, input logic ep);
    exp_t e;
    e.due  = cyc + RL;
    e.dat  = ed;
    e.perr = ep;
    sbq.push_back(e);
  endtask

  // Read-data scoreboard: every rvalid must match the oldest pending read, on its due cycle.
  always @(negedge clk) begin
    #1;
    if (rvalid === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected: rvalid=1 data=%h at cycle %0d, none pending", data, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (data !== mon_e.dat || perr !== mon_e.perr || cyc != mon_e.due) begin
          bad++;
          $display("FAIL read_data: got data=%h perr=%b cycle=%0d want data=%h perr=%b cycle=%0d",
                   data, perr, cyc, mon_e.dat, mon_e.perr, mon_e.due);
        end
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
      total++;
      bad++;
      $display("FAIL read_late: no rvalid by cycle %0d, want data=%h at cycle %0d",
               cyc, sbq[0].dat, sbq[0].due);
      void'(sbq.pop_front());
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (ready !== 1'b1) check({name, "_ready_timeout"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_cmd(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] ed, input logic ep,
                        input logic eerr, input logic erdy, input string name);
    wait_ready(name);
    read   = rd;
    write  = wr;
    addr   = a;
    tb_dat = d;
    tb_drv = wr;
    if (rd && !wr) push_exp(ed, ep);
    @(negedge clk);
    read   = 1'b0;
    write  = 1'b0;
    tb_drv = 1'b0;
    #2;
    check({name, "_cmd_err"}, {31'd0, cmd_err}, {31'd0, eerr});
    check({name, "_ready"}, {31'd0, ready}, {31'd0, erdy});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          rd    wr    addr    wdata  exp rd  cmd_err ready
    vt[0]  = '{1'b1, 1'b0, 5'd31, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 5'd3,  8'hA5, 8'h00, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 5'd3,  8'h00, 8'hA5, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 5'd7,  8'h3C, 8'h00, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 5'd7,  8'h00, 8'h00, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 5'd0,  8'hFF, 8'h00, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 5'd31, 8'h81, 8'h00, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 5'd0,  8'h00, 8'hFF, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 5'd31, 8'h00, 8'h81, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 5'd3,  8'h5A, 8'h00, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'h5A, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 5'd8,  8'h00, 8'h00, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_ready",   {31'd0, ready},   32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("rst_perr",    {31'd0, perr},    32'd0);

    // Reset in the middle of INIT must restart the full sweep
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midinit_rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    count_init(n);
    check("init_ready_cycles", n, 32'd32);

    for (int i = 0; i < 12; i++) begin
      do_cmd(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].ed, 1'b0,
             vt[i].eerr, vt[i].erdy, $sformatf("vec%0d", i));
    end

    // Bus released around RD_DRIVE; a write while busy is dropped without cmd_err
    do_cmd(1'b0, 1'b1, 5'd3, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, "rewrite3");
    wait_ready("probe");
    read   = 1'b1;
    addr   = 5'd3;
    tb_drv = 1'b1;
    tb_dat = 8'h00;
    push_exp(8'hA5, 1'b0);
    #2;
    check("probe_bus_idle", {24'd0, data}, 32'h00);
    @(negedge clk);
    read   = 1'b0;
    write  = 1'b1;
    addr   = 5'd3;
    tb_dat = 8'h00;
    #2;
    check("probe_bus_wait", {24'd0, data}, 32'h00);
    check("probe_busy_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    write  = 1'b0;
    tb_drv = 1'b0;
    #2;
    check("busy_write_no_cmd_err", {31'd0, cmd_err}, 32'd0);
    @(negedge clk);
    tb_drv = 1'b1;
    tb_dat = 8'h00;
    #2;
    check("probe_bus_after", {24'd0, data}, 32'h00);
    check("probe_after_ready", {31'd0, ready}, 32'd1);
    tb_drv = 1'b0;
    do_cmd(1'b1, 1'b0, 5'd3, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, "busy_write_dropped");

    // Reset while a read sits in RD_WAIT: the read is abandoned, memory re-zeroed
    wait_ready("abort");
    read = 1'b1;
    addr = 5'd3;
    @(negedge clk);
    read  = 1'b0;
    rst_n = 1'b0;
    #2;
    check("abort_ready",   {31'd0, ready},   32'd0);
    check("abort_rvalid",  {31'd0, rvalid},  32'd0);
    check("abort_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("abort_perr",    {31'd0, perr},    32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    count_init(n);
    check("reinit_ready_cycles", n, 32'd32);
    do_cmd(1'b1, 1'b0, 5'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "after_abort_rd3");

`ifdef MEMORY_SP_M_PARITY_EN
    do_cmd(1'b0, 1'b1, 5'd5, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, "par_wr5");
    dut.mem[5][0] = ~dut.mem[5][0];
    do_cmd(1'b1, 1'b0, 5'd5, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "par_rd5");
`endif

    wait_ready("final");
    repeat (4) @(negedge clk);
    #2;
    check("scoreboard_drained", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
